// File: rtl/lif_array_scheduler_if.sv
// Handshake bundle between the LIF scheduler, the input-current source and the
// spike-event consumer. The scheduler is the master of both channels.
interface lif_array_scheduler_if #(
  parameter int IDX_W = 3
);
  // current-fetch channel
  logic             cur_req;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_valid;
  logic [7:0]       cur_data;
  // spike-event channel
  logic             spk_valid;
  logic [IDX_W-1:0] spk_idx;
  logic             spk_ready;

  modport master (
    output cur_req, cur_idx, spk_valid, spk_idx,
    input  cur_valid, cur_data, spk_ready
  );

  modport slave (
    input  cur_req, cur_idx, spk_valid, spk_idx,
    output cur_valid, cur_data, spk_ready
  );
endinterface

// File: rtl/lif_array_scheduler.sv
// LIF array scheduler: one shared leak/integrate/fire datapath walks all neurons
// once per step_start. Membrane state and adaptive thresholds live in internal arrays.
module lif_array_scheduler #(
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = 3,
  parameter int THR_INIT    = 100,
  parameter int THR_MIN     = 8,
  parameter int THR_MAX     = 220
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_start,
  input  logic                  learn_en,
  lif_array_scheduler_if.master bus,
  output logic                  busy,
  output logic                  step_done,
  output logic                  overrun,
  input  logic [IDX_W-1:0]      dbg_idx,
  output logic [7:0]            dbg_state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_UPDATE = 3'd2;
  localparam logic [2:0] ST_EMIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_NEURONS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       THR_INIT_V = 8'(THR_INIT);
  localparam logic [7:0]       THR_MIN_V  = 8'(THR_MIN);
  localparam logic [7:0]       THR_MAX_V  = 8'(THR_MAX);

  // Leak by 112/128 then add the input current, saturating at 255.
  function automatic logic [7:0] leak_integrate(input logic [7:0] s, input logic [7:0] c);
    logic [15:0] leak;
    logic [15:0] sum;
    leak = ({8'd0, s} * 16'd112) >> 7;
    sum  = {8'd0, c} + leak;
    if (sum > 16'd255) begin
      return 8'd255;
    end else begin
      return sum[7:0];
    end
  endfunction

  // Grow threshold by 1/8, clamped to the ceiling.
  function automatic logic [7:0] thr_grow(input logic [7:0] t);
    logic [8:0] g;
    g = {1'b0, t} + {4'd0, t[7:3]};
    if (g > {1'b0, THR_MAX_V}) begin
      return THR_MAX_V;
    end else begin
      return g[7:0];
    end
  endfunction

  // Shrink threshold by 1/16, clamped to the floor.
  function automatic logic [7:0] thr_decay(input logic [7:0] t);
    logic [7:0] d;
    d = t - {4'd0, t[7:4]};
    if (d < THR_MIN_V) begin
      return THR_MIN_V;
    end else begin
      return d;
    end
  endfunction

  logic [2:0]       fsm_q, fsm_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cur_lat_q, cur_lat_d;
  logic [7:0]       state_q [NUM_NEURONS];
  logic [7:0]       state_d [NUM_NEURONS];
  logic [7:0]       thr_q   [NUM_NEURONS];
  logic [7:0]       thr_d   [NUM_NEURONS];
  logic             cur_req_q, cur_req_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic             spk_valid_q, spk_valid_d;
  logic [IDX_W-1:0] spk_idx_q, spk_idx_d;
  logic             busy_q, busy_d;
  logic             step_done_q, step_done_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       s_s, t_s;
  logic             spike_s;

  // Sequencer, datapath writeback and next-value decode of the registered outputs.
  always_comb begin
    fsm_d     = fsm_q;
    idx_d     = idx_q;
    cur_lat_d = cur_lat_q;
    state_d   = state_q;
    thr_d     = thr_q;
    s_s       = state_q[idx_q];
    t_s       = thr_q[idx_q];
    spike_s   = (s_s >= t_s);

    case (fsm_q)
      ST_IDLE: begin
        if (step_start) begin
          fsm_d = ST_FETCH;
          idx_d = IDX_ZERO;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (bus.cur_valid) begin
          cur_lat_d = bus.cur_data;
          fsm_d     = ST_UPDATE;
        end else begin
          fsm_d = ST_FETCH;
        end
      end
      ST_UPDATE: begin
        // spike is decided on the pre-update membrane value
        if (spike_s) begin
          state_d[idx_q] = 8'd0;
        end else begin
          state_d[idx_q] = leak_integrate(s_s, cur_lat_q);
        end
        if (learn_en && spike_s && (t_s < THR_MAX_V)) begin
          thr_d[idx_q] = thr_grow(t_s);
        end else if (learn_en && !spike_s && (t_s > THR_MIN_V)) begin
          thr_d[idx_q] = thr_decay(t_s);
        end else begin
          thr_d[idx_q] = t_s;
        end
        if (spike_s) begin
          fsm_d = ST_EMIT;
        end else if (idx_q == LAST_IDX) begin
          fsm_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
          fsm_d = ST_FETCH;
        end
      end
      ST_EMIT: begin
        if (!bus.spk_ready) begin
          fsm_d = ST_EMIT;
        end else if (idx_q == LAST_IDX) begin
          fsm_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
          fsm_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        fsm_d = ST_IDLE;
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase

    cur_req_d   = (fsm_d == ST_FETCH);
    cur_idx_d   = idx_d;
    spk_valid_d = (fsm_d == ST_EMIT);
    spk_idx_d   = idx_d;
    busy_d      = (fsm_d != ST_IDLE);
    step_done_d = (fsm_d == ST_DONE);
    // a start seen in any non-IDLE state (DONE included) is dropped and flagged
    overrun_d   = step_start && (fsm_q != ST_IDLE);
  end

  // State registers with synchronous reset; reset mid-step abandons the step.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      idx_q       <= IDX_ZERO;
      cur_lat_q   <= 8'd0;
      cur_req_q   <= 1'b0;
      cur_idx_q   <= IDX_ZERO;
      spk_valid_q <= 1'b0;
      spk_idx_q   <= IDX_ZERO;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        state_q[i] <= 8'd0;
        thr_q[i]   <= THR_INIT_V;
      end
    end else begin
      fsm_q       <= fsm_d;
      idx_q       <= idx_d;
      cur_lat_q   <= cur_lat_d;
      cur_req_q   <= cur_req_d;
      cur_idx_q   <= cur_idx_d;
      spk_valid_q <= spk_valid_d;
      spk_idx_q   <= spk_idx_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
      overrun_q   <= overrun_d;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        state_q[i] <= state_d[i];
        thr_q[i]   <= thr_d[i];
      end
    end
  end

  assign bus.cur_req   = cur_req_q;
  assign bus.cur_idx   = cur_idx_q;
  assign bus.spk_valid = spk_valid_q;
  assign bus.spk_idx   = spk_idx_q;
  assign busy          = busy_q;
  assign step_done     = step_done_q;
  assign overrun       = overrun_q;
  // out-of-range debug selects read as zero
  assign dbg_state = ({1'b0, dbg_idx} < (IDX_W+1)'(NUM_NEURONS)) ? state_q[dbg_idx] : 8'd0;

endmodule
